// File: rtl/regfile_pkg.sv
// Shared constants for the scoreboarded register file.
// Imported by regfile_sb and rf_scoreboard.
package regfile_pkg;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int ZERO_IDX       = 0;
endpackage

// File: rtl/rf_scoreboard.sv
// Pending-bit scoreboard: busy bits, issue acceptance and busy count.
// Register 0 is never tracked.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    iss_valid,
    input  logic [ADDR_WIDTH-1:0]   iss_idx,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   wa,
    output logic                    iss_ok,
    output logic [2**ADDR_WIDTH-1:0] pending,
    output logic [ADDR_WIDTH:0]     pend_cnt
);
    localparam int NREG = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZIDX = ADDR_WIDTH'(ZERO_IDX);

    logic [NREG-1:0]     pend_q, pend_d;
    logic [ADDR_WIDTH:0] cnt_q, cnt_d;
    logic                wb_nz, iss_nz, iss_acc, inc, dec;

    always_comb begin
        wb_nz   = we && (wa != ZIDX);
        iss_nz  = iss_idx != ZIDX;
        iss_ok  = !iss_nz || !pend_q[iss_idx] || (we && wa == iss_idx);
        iss_acc = iss_valid && iss_ok && iss_nz;
        inc     = iss_acc && !pend_q[iss_idx];
        // A writeback freeing the very register being reissued nets to zero
        dec     = wb_nz && pend_q[wa] && !(iss_acc && iss_idx == wa);

        pend_d = pend_q;
        if (wb_nz) begin
            pend_d[wa] = 1'b0;
        end
        if (iss_acc) begin
            pend_d[iss_idx] = 1'b1;
        end

        cnt_d = cnt_q;
        if (inc && !dec) begin
            cnt_d = cnt_q + (ADDR_WIDTH+1)'(1);
        end else if (dec && !inc) begin
            cnt_d = cnt_q - (ADDR_WIDTH+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pending  = pend_q;
    assign pend_cnt = cnt_q;
endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with write bypass and a pending scoreboard.
// Register 0 reads as zero and is never busy.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_RD     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] ra,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd,
    output logic [NUM_RD-1:0]            rd_rdy,
    input  logic                         iss_valid,
    input  logic [ADDR_WIDTH-1:0]        iss_idx,
    output logic                         iss_ok,
    input  logic                         we,
    input  logic [ADDR_WIDTH-1:0]        wa,
    input  logic [DATA_WIDTH-1:0]        wd,
    output logic [ADDR_WIDTH:0]          pend_cnt
);
    localparam int NREG = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZIDX = ADDR_WIDTH'(ZERO_IDX);

    logic [DATA_WIDTH-1:0] regs_q [NREG];
    logic [NREG-1:0]       pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) begin
                regs_q[k] <= '0;
            end
        end else if (we && wa != ZIDX) begin
            regs_q[wa] <= wd;
        end
    end

    rf_scoreboard #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .iss_valid(iss_valid),
        .iss_idx  (iss_idx),
        .we       (we),
        .wa       (wa),
        .iss_ok   (iss_ok),
        .pending  (pending),
        .pend_cnt (pend_cnt)
    );

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        logic                  zero;
        logic                  byp;

        assign addr = ra[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign zero = addr == ZIDX;
        assign byp  = we && (wa == addr) && !zero;

        assign rd[p*DATA_WIDTH +: DATA_WIDTH] =
            zero ? '0 : (byp ? wd : regs_q[addr]);
        assign rd_rdy[p] = zero || byp || !pending[addr];
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed plus random bench for regfile_sb (four read ports).
// Expectations come from an array-based model of the register rules.
module tb_regfile_sb;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NR   = 4;
    localparam int NREG = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR*AW-1:0] ra;
    logic [NR*DW-1:0] rd;
    logic [NR-1:0]   rd_rdy;
    logic            iss_valid;
    logic [AW-1:0]   iss_idx;
    logic            iss_ok;
    logic            we;
    logic [AW-1:0]   wa;
    logic [DW-1:0]   wd;
    logic [AW:0]     pend_cnt;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mregs [NREG];
    bit            mpend [NREG];

    regfile_sb #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .NUM_RD    (NR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ra       (ra),
        .rd       (rd),
        .rd_rdy   (rd_rdy),
        .iss_valid(iss_valid),
        .iss_idx  (iss_idx),
        .iss_ok   (iss_ok),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .pend_cnt (pend_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rdp(input int p);
        return rd[p*DW +: DW];
    endfunction

    function automatic int rap(input int p);
        return int'(ra[p*AW +: AW]);
    endfunction

    task automatic set_ra(input int p, input int a);
        ra[p*AW +: AW] = AW'(a);
    endtask

    function automatic logic [DW-1:0] exp_rd(input int a);
        if (a == 0) return '0;
        if (we && int'(wa) == a) return wd;
        return mregs[a];
    endfunction

    function automatic logic exp_rdy(input int a);
        return (a == 0) || (we && int'(wa) == a) || !mpend[a];
    endfunction

    function automatic logic exp_ok();
        int i = int'(iss_idx);
        return (i == 0) || !mpend[i] || (we && wa == iss_idx);
    endfunction

    function automatic int exp_cnt();
        int c = 0;
        for (int k = 0; k < NREG; k++) c += int'(mpend[k]);
        return c;
    endfunction

    task automatic model_update();
        bit ok = exp_ok();
        if (rst) begin
            for (int k = 0; k < NREG; k++) begin
                mregs[k] = '0;
                mpend[k] = 1'b0;
            end
        end else begin
            if (we && wa != 0) begin
                mregs[wa] = wd;
                mpend[wa] = 1'b0;
            end
            if (iss_valid && ok && iss_idx != 0) mpend[iss_idx] = 1'b1;
        end
    endtask

    task automatic check_all(input string ph);
        for (int p = 0; p < NR; p++) begin
            chk($sformatf("%s_rd%0d", ph, p), rdp(p), exp_rd(rap(p)));
            chk($sformatf("%s_rdy%0d", ph, p), DW'(rd_rdy[p]),
                DW'(exp_rdy(rap(p))));
        end
        chk({ph, "_iss_ok"}, DW'(iss_ok), DW'(exp_ok()));
        chk({ph, "_pend_cnt"}, DW'(pend_cnt), DW'(exp_cnt()));
    endtask

    task automatic idle();
        rst = 1'b0; we = 1'b0; iss_valid = 1'b0;
        wa = '0; wd = '0; iss_idx = '0; ra = '0;
    endtask

    task automatic step(input string ph);
        #1;
        check_all(ph);
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        model_update();
        @(negedge clk);
        idle();
        #1;
        chk("post_rst_cnt", DW'(pend_cnt), 32'd0);
        chk("post_rst_ok", DW'(iss_ok), 32'd1);
        chk("post_rst_rdy", DW'(rd_rdy), 32'hF);
        step("reset");

        // write then read back, register 0 on port 1
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
        step("wr5");
        idle(); set_ra(0, 5); set_ra(1, 0);
        #1;
        chk("rd5", rdp(0), 32'hDEADBEEF);
        chk("rd5_rdy", DW'(rd_rdy[0]), 32'd1);
        chk("rd_zero", rdp(1), 32'd0);
        step("rd5");

        // issue 7, blocked reissue, bypassed writeback
        iss_valid = 1'b1; iss_idx = 5'd7;
        step("iss7");
        idle(); set_ra(0, 7);
        #1;
        chk("cnt_after_iss7", DW'(pend_cnt), 32'd1);
        chk("rdy7_busy", DW'(rd_rdy[0]), 32'd0);
        iss_valid = 1'b1; iss_idx = 5'd7;
        #1;
        chk("iss_ok7_blocked", DW'(iss_ok), 32'd0);
        step("reiss7");
        idle(); set_ra(0, 7);
        #1;
        chk("cnt_after_reiss7", DW'(pend_cnt), 32'd1);
        we = 1'b1; wa = 5'd7; wd = 32'h1234;
        #1;
        chk("byp7_rd", rdp(0), 32'h1234);
        chk("byp7_rdy", DW'(rd_rdy[0]), 32'd1);
        step("wb7");
        idle();
        #1;
        chk("cnt_after_wb7", DW'(pend_cnt), 32'd0);

        // same-cycle issue and writeback to 3: issue wins
        iss_valid = 1'b1; iss_idx = 5'd3;
        we = 1'b1; wa = 5'd3; wd = 32'h55;
        step("iss_wb3");
        idle(); set_ra(0, 3);
        #1;
        chk("rd3", rdp(0), 32'h55);
        chk("rdy3_busy", DW'(rd_rdy[0]), 32'd0);
        chk("cnt3", DW'(pend_cnt), 32'd1);
        we = 1'b1; wa = 5'd3; wd = 32'h66;
        step("wb3");

        // register 0 ignores writes and issues
        idle();
        we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF;
        iss_valid = 1'b1; iss_idx = 5'd0;
        #1;
        chk("iss_ok0", DW'(iss_ok), 32'd1);
        step("wr0");
        idle(); set_ra(0, 0);
        #1;
        chk("rd0_zero", rdp(0), 32'd0);
        chk("rd0_rdy", DW'(rd_rdy[0]), 32'd1);
        chk("cnt_r0", DW'(pend_cnt), 32'd0);

        // fill the scoreboard then reset
        for (int i = 1; i < NREG; i++) begin
            idle();
            iss_valid = 1'b1; iss_idx = AW'(i);
            step("fill");
        end
        idle();
        #1;
        chk("cnt_full", DW'(pend_cnt), 32'd31);
        rst = 1'b1; we = 1'b1; wa = 5'd9; wd = 32'hABCD;
        step("rst_mid");
        idle();
        #1;
        chk("cnt_after_rst", DW'(pend_cnt), 32'd0);
        for (int a = 0; a < NREG; a++) begin
            set_ra(0, a);
            #1;
            chk($sformatf("rst_rd_%0d", a), rdp(0), 32'd0);
            chk($sformatf("rst_rdy_%0d", a), DW'(rd_rdy[0]), 32'd1);
        end

        // four ports reading distinct registers at once
        for (int k = 0; k < 4; k++) begin
            idle();
            we = 1'b1; wa = AW'(10 + k); wd = 32'hA0000000 + 32'(k);
            step("wr4");
        end
        idle();
        for (int p = 0; p < NR; p++) set_ra(p, 10 + p);
        #1;
        for (int p = 0; p < NR; p++)
            chk($sformatf("port%0d", p), rdp(p), 32'hA0000000 + 32'(p));
        step("rd4");

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 49) == 0);
            we        = 1'($urandom_range(0, 1));
            wa        = AW'($urandom);
            wd        = $urandom;
            iss_valid = 1'($urandom_range(0, 1));
            iss_idx   = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
            for (int p = 0; p < NR; p++)
                set_ra(p, ($urandom_range(0, 3) == 0) ? int'(wa)
                                                      : $urandom_range(0, 31));
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter ADDR_WIDTH, default 5: register index width; the file holds 2**ADDR_WIDTH entries.
REQ-002 Parameter DATA_WIDTH, default 32: register data width.
REQ-003 Parameter NUM_RD, default 2: number of independent read ports, legal range 1..4.
REQ-004 Port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port ra, input, NUM_RD*ADDR_WIDTH: read addresses; port i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-007 Port rd, output, NUM_RD*DATA_WIDTH: read data, sliced the same way as ra.
REQ-008 Port rd_rdy, output, NUM_RD: bit i high means rd slice i is valid, i.e. not pending.
REQ-009 Port iss_valid, input, 1: issue request; marks register iss_idx pending.
REQ-010 Port iss_idx, input, ADDR_WIDTH: destination register of the issuing instruction.
REQ-011 Port iss_ok, output, 1: iss_idx is not pending; issue is accepted only when iss_valid and iss_ok are both high.
REQ-012 Port we, input, 1: writeback strobe.
REQ-013 Port wa, input, ADDR_WIDTH: writeback address.
REQ-014 Port wd, input, DATA_WIDTH: writeback data.
REQ-015 Port pend_cnt, output, ADDR_WIDTH+1: number of currently pending registers.

Function
REQ-016 Register 0 SHALL always read as 0 with rd_rdy=1; writes and issues to index 0 SHALL be ignored (no data change, no pending bit, iss_ok=1).
REQ-017 Reads SHALL be combinational: rd slice i = regs[ra slice i], with no added cycle of latency.
REQ-018 Write bypass: if we=1 and wa equals ra slice i (nonzero) in the same cycle, rd slice i SHALL equal wd and rd_rdy bit i SHALL be 1.
REQ-019 On each rising edge with we=1 and wa nonzero, regs[wa] SHALL take wd and pending[wa] SHALL clear.
REQ-020 On each rising edge with accepted issue and iss_idx nonzero, pending[iss_idx] SHALL set.
REQ-021 If the same nonzero index is written back and issued in the same cycle, the issue SHALL win: data is written and pending stays set.
REQ-022 Without bypass, rd_rdy bit i SHALL equal the inverse of pending[ra slice i].
REQ-023 iss_ok SHALL be low when pending[iss_idx] is set, unless we=1 with wa equal to iss_idx in that cycle (WAW resolved by the same-cycle writeback).
REQ-024 An issue while iss_ok=0 SHALL change no state.
REQ-025 A writeback to a non-pending register SHALL update data, and pend_cnt SHALL not underflow.
REQ-026 pend_cnt SHALL always equal the population count of the pending bits; per cycle it changes by +1 (set only), -1 (clear only) or 0 (both, neither, or the same register).
REQ-027 pend_cnt SHALL be a registered output updated in the same edge as the pending bits.

Reset
REQ-028 While rst=1 at a rising edge, all regs SHALL clear to 0, all pending bits to 0 and pend_cnt to 0; rst SHALL override we and iss_valid in that cycle.
REQ-029 In the cycle after reset, rd SHALL read 0, rd_rdy SHALL be all ones and iss_ok SHALL be 1.
REQ-030 Assertion of rst mid-sequence with registers pending SHALL discard all pending state, so no stale busy bits remain.

Structure
REQ-031 A shared package regfile_pkg SHALL hold the ZERO_IDX constant and the default ADDR_WIDTH and DATA_WIDTH.
REQ-032 The pending-bit vector, the iss_ok logic and pend_cnt SHALL live in one sub-module, rf_scoreboard; the data array, read muxes and bypass SHALL stay in regfile_sb.
REQ-033 The read-port logic SHALL be generated per port; it SHALL not be hand-unrolled.

Verification
REQ-034 Reset, then write wa=5 wd=0xDEADBEEF; next cycle ra0=5 -> rd0=0xDEADBEEF, rd_rdy0=1; ra1=0 -> rd1=0.
REQ-035 Issue idx=7 -> next cycle pend_cnt=1, ra0=7 gives rd_rdy0=0, and a second issue to 7 sees iss_ok=0 with pend_cnt unchanged; then we=1 wa=7 wd=0x1234 with ra0=7 -> rd0=0x1234 and rd_rdy0=1 in that same cycle, and pend_cnt=0 on the next cycle.
REQ-036 Same cycle: issue idx=3 and we=1 wa=3 wd=0x55 -> regs[3]=0x55, pending[3]=1, pend_cnt=1.
REQ-037 Write wa=0 wd=0xFFFFFFFF and issue idx=0 -> rd reads 0, rd_rdy=1, pend_cnt=0.
REQ-038 Issue indices 1..31 on consecutive cycles -> pend_cnt=31; assert rst for one cycle -> pend_cnt=0, all rd_rdy=1, all data reads 0.
REQ-039 Run with NUM_RD=4, all four ports reading distinct written registers simultaneously -> each slice returns its own data.
